uart_rx_oversampled: RTL and testbench

//   UART receiver sitting directly downstream of oversampling_clk_generator: consumes its

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_sync.sv | 38 +++
 rtl/uart_rx_oversampled.sv | 155 +++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encodings, default frame width
// and the oversampling factor floor, plus a helper that applies that floor.
package uart_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam int unsigned DEFAULT_DATA_BITS = 8;
  localparam int unsigned FAC_W             = 5;
  localparam logic [4:0]  MIN_OVERSAMPLING  = 5'd4;

  // Factors below the floor cannot place a mid-bit sample, so they are raised to it.
  function automatic logic [FAC_W-1:0] clamp_factor(input logic [FAC_W-1:0] f);
    return (f < MIN_OVERSAMPLING) ? MIN_OVERSAMPLING : f;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning for the UART receiver.
// Ports:
//   clk, rst            clock and async active-low reset
//   rx                  asynchronous serial line (idle high)
//   oversampling_clock  oversampling clock, synchronous to clk
//   rx_s                rx after SYNC_STAGES flops (registered)
//   tick_c              one-clk pulse on each rising edge of oversampling_clock
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic oversampling_clock,
  output logic rx_s,
  output logic tick_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   osc_d;

  // Synchroniser presets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
      osc_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      osc_d  <= oversampling_clock;
    end
  end

  assign rx_s   = sync_q[SYNC_STAGES-1];
  assign tick_c = oversampling_clock & ~osc_d;

endmodule

// File: rtl/uart_rx_oversampled.sv
// UART receiver driven by an external oversampling clock. Detects a start
// bit, samples each bit once at its centre and reports each frame with a
// one-cycle rx_valid (good stop bit) or frame_error (stop bit sampled 0).
// Ports:
//   clk, rst             clock and async active-low reset
//   oversampling_clock   oversampling clock, synchronous to clk
//   oversampling_factor  ticks per bit, latched at each start bit (min 4)
//   rx                   asynchronous serial line, idle high
//   rx_data              payload of the last good frame
//   rx_valid             one-clk pulse when rx_data is updated
//   frame_error          one-clk pulse when the stop bit is 0
//   busy                 high whenever the receiver is not idle
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = DEFAULT_DATA_BITS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 oversampling_clock,
  input  logic [FAC_W-1:0]     oversampling_factor,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS + 1);

  logic                 rx_s;
  logic                 tick;
  logic [1:0]           state, state_next;
  logic [FAC_W-1:0]     sample_cnt, sample_cnt_next;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_next;
  logic [FAC_W-1:0]     fac, fac_next;
  logic [FAC_W-1:0]     half_c;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic [DATA_BITS-1:0] rx_data_next;
  logic                 rx_valid_next, frame_error_next, busy_next;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk               (clk),
    .rst               (rst),
    .rx                (rx),
    .oversampling_clock(oversampling_clock),
    .rx_s              (rx_s),
    .tick_c            (tick)
  );

  assign half_c = {1'b0, fac[FAC_W-1:1]};

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      sample_cnt  <= '0;
      bit_cnt     <= '0;
      fac         <= MIN_OVERSAMPLING;
      shreg       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      sample_cnt  <= sample_cnt_next;
      bit_cnt     <= bit_cnt_next;
      fac         <= fac_next;
      shreg       <= shreg_next;
      rx_data     <= rx_data_next;
      rx_valid    <= rx_valid_next;
      frame_error <= frame_error_next;
      busy        <= busy_next;
    end
  end

  // Next-state logic: at most one transition per oversampling tick.
  always_comb begin
    state_next       = state;
    sample_cnt_next  = sample_cnt;
    bit_cnt_next     = bit_cnt;
    fac_next         = fac;
    shreg_next       = shreg;
    rx_data_next     = rx_data;
    rx_valid_next    = 1'b0;
    frame_error_next = 1'b0;

    case (state)
      IDLE: begin
        if (tick && !rx_s) begin
          state_next      = START;
          sample_cnt_next = 5'd1;
          fac_next        = clamp_factor(oversampling_factor);
        end
      end
      START: begin
        if (tick) begin
          // Centre of the start bit: a high line here was only a glitch.
          if (sample_cnt == half_c - 5'd1) begin
            sample_cnt_next = '0;
            if (!rx_s) begin
              state_next   = DATA;
              bit_cnt_next = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            sample_cnt_next = sample_cnt + 5'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (sample_cnt == fac - 5'd1) begin
            shreg_next      = {rx_s, shreg[DATA_BITS-1:1]};
            sample_cnt_next = '0;
            bit_cnt_next    = bit_cnt + BIT_CNT_W'(1);
            if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
              state_next = STOP;
            end
          end else begin
            sample_cnt_next = sample_cnt + 5'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          // Leaving at mid-stop lets a start bit straight after the stop bit be caught.
          if (sample_cnt == fac - 5'd1) begin
            sample_cnt_next = '0;
            state_next      = IDLE;
            if (rx_s) begin
              rx_data_next  = shreg;
              rx_valid_next = 1'b1;
            end else begin
              frame_error_next = 1'b1;
            end
          end else begin
            sample_cnt_next = sample_cnt + 5'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: table of frames, hand-written corner
// sequences (glitch, factor change, mid-frame reset) and random frames
// checked against a frame-level reference model.
module tb_uart_rx_oversampled;

  logic       clk = 1'b0;
  logic       rst;
  logic       oversampling_clock = 1'b0;
  logic [4:0] oversampling_factor;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int osc_ph = 0;

  typedef struct {
    logic       ferr;
    logic [7:0] data;
  } ev_t;
  ev_t evq[$];

  typedef struct {
    int         bit_fac;
    logic [4:0] dut_fac;
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic       exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  uart_rx_oversampled dut (
    .clk                (clk),
    .rst                (rst),
    .oversampling_clock (oversampling_clock),
    .oversampling_factor(oversampling_factor),
    .rx                 (rx),
    .rx_data            (rx_data),
    .rx_valid           (rx_valid),
    .frame_error        (frame_error),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  // Oversampling clock: one-clk-wide high pulse every 4 clks.
  always @(negedge clk) begin
    osc_ph = osc_ph + 1;
    oversampling_clock = ((osc_ph % 4) == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Collect every result pulse; a pulse wider than one clk shows up as an extra event.
  always @(negedge clk) begin
    if (rst && (rx_valid || frame_error)) begin
      check("valid_and_ferr_exclusive", 32'(rx_valid && frame_error), 32'd0);
      evq.push_back('{ferr: frame_error, data: rx_data});
    end
  end

  // Returns at the negedge following the n-th tick edge.
  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      do @(posedge clk); while (oversampling_clock !== 1'b1);
      @(negedge clk);
    end
  endtask

  // Bit idx 0 = start, 1..8 = data LSB first, 9 = stop (driven for half a bit, then idle).
  task automatic send_frame(input int bit_fac, input logic [7:0] data, input logic stop,
                            input int chg_idx = -1, input logic [4:0] chg_fac = 5'd0,
                            input int stop_idx = 10);
    logic [7:0] d;
    int half;
    d = data;
    half = bit_fac / 2;
    for (int idx = 0; idx < 10; idx++) begin
      if (idx == stop_idx) return;
      if (idx == chg_idx) oversampling_factor = chg_fac;
      if (idx == 0) begin
        rx = 1'b0;
        wait_ticks(bit_fac);
      end else if (idx < 9) begin
        rx = d[idx-1];
        wait_ticks(bit_fac);
      end else begin
        rx = stop;
        wait_ticks(half);
        rx = 1'b1;
        wait_ticks(bit_fac - half);
      end
    end
  endtask

  task automatic expect_result(input string name, input logic exp_ferr, input logic [7:0] exp_data);
    int w;
    ev_t ev;
    w = 0;
    while (evq.size() == 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (evq.size() == 0) begin
      check({name, "_event_present"}, 32'd0, 32'd1);
    end else begin
      ev = evq.pop_front();
      check({name, "_ferr"}, 32'(ev.ferr), 32'(exp_ferr));
      if (!exp_ferr) check({name, "_data"}, 32'(ev.data), 32'(exp_data));
    end
    check({name, "_extra_events"}, 32'(evq.size()), 32'd0);
    check({name, "_rx_data_hold"}, 32'(rx_data), 32'(exp_data));
    check({name, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic run_frame(input string name, input int bit_fac, input logic [4:0] dut_fac,
                           input logic [7:0] data, input logic stop, input int gap,
                           input logic exp_ferr, input logic [7:0] exp_data);
    oversampling_factor = dut_fac;
    rx = 1'b1;
    wait_ticks(gap);
    send_frame(bit_fac, data, stop);
    expect_result(name, exp_ferr, exp_data);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    logic [7:0] last_good;
    int bf;
    logic [4:0] df;
    logic [7:0] d;
    logic st;

    vecs[0]  = '{16, 5'd16, 8'hA5, 1'b1, 2, 1'b0, 8'hA5};
    vecs[1]  = '{ 8, 5'd8,  8'h3C, 1'b1, 2, 1'b0, 8'h3C};
    vecs[2]  = '{ 8, 5'd8,  8'hC3, 1'b1, 0, 1'b0, 8'hC3};
    vecs[3]  = '{16, 5'd16, 8'hA5, 1'b1, 1, 1'b0, 8'hA5};
    vecs[4]  = '{16, 5'd16, 8'h55, 1'b0, 0, 1'b1, 8'hA5};
    vecs[5]  = '{ 4, 5'd4,  8'h00, 1'b1, 1, 1'b0, 8'h00};
    vecs[6]  = '{ 4, 5'd2,  8'hFF, 1'b1, 0, 1'b0, 8'hFF};
    vecs[7]  = '{31, 5'd31, 8'h5A, 1'b1, 3, 1'b0, 8'h5A};
    vecs[8]  = '{ 5, 5'd5,  8'h81, 1'b0, 0, 1'b1, 8'h5A};
    vecs[9]  = '{ 4, 5'd3,  8'hE7, 1'b1, 1, 1'b0, 8'hE7};
    vecs[10] = '{ 9, 5'd9,  8'h01, 1'b0, 0, 1'b1, 8'hE7};
    vecs[11] = '{16, 5'd16, 8'h80, 1'b1, 0, 1'b0, 8'h80};

    rst = 1'b0;
    rx = 1'b1;
    oversampling_factor = 5'd16;
    repeat (4) @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_frame_error", 32'(frame_error), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    wait_ticks(2);
    check("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].bit_fac, vecs[i].dut_fac, vecs[i].data,
                vecs[i].stop, vecs[i].gap, vecs[i].exp_ferr, vecs[i].exp_data);
    end
    last_good = 8'h80;

    // Short low pulse: start bit rejected at its centre.
    oversampling_factor = 5'd16;
    wait_ticks(2);
    rx = 1'b0;
    wait_ticks(3);
    check("glitch_busy_in_start", 32'(busy), 32'd1);
    rx = 1'b1;
    wait_ticks(16);
    check("glitch_no_events", 32'(evq.size()), 32'd0);
    check("glitch_busy_idle", 32'(busy), 32'd0);
    check("glitch_rx_data_hold", 32'(rx_data), 32'(last_good));

    // Factor changed mid-frame is ignored until the next start bit.
    oversampling_factor = 5'd16;
    wait_ticks(2);
    send_frame(16, 8'h81, 1'b1, 3, 5'd8);
    expect_result("fac_change_frame", 1'b0, 8'h81);
    run_frame("fac_change_next", 8, 5'd8, 8'h7E, 1'b1, 0, 1'b0, 8'h7E);

    // Asynchronous reset in the middle of data bit 4.
    oversampling_factor = 5'd16;
    wait_ticks(2);
    send_frame(16, 8'h99, 1'b1, -1, 5'd0, 6);
    check("midreset_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midreset_rx_data", 32'(rx_data), 32'd0);
    check("midreset_rx_valid", 32'(rx_valid), 32'd0);
    check("midreset_frame_error", 32'(frame_error), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    wait_ticks(2);
    check("midreset_no_events", 32'(evq.size()), 32'd0);
    run_frame("after_reset", 16, 5'd16, 8'h0F, 1'b1, 0, 1'b0, 8'h0F);
    last_good = 8'h0F;

    // Random frames against the frame-level model.
    for (int i = 0; i < 16; i++) begin
      bf = $urandom_range(4, 31);
      df = (bf == 4) ? 5'($urandom_range(0, 4)) : 5'(bf);
      d  = 8'($urandom);
      st = ($urandom_range(0, 4) != 0);
      if (st) last_good = d;
      run_frame($sformatf("rand%0d", i), bf, df, d, st, $urandom_range(0, 2), !st, last_good);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
